// File: rtl/demux4_reg_pkg.sv
// Shared constants and types for the registered 1-to-4 demultiplexer.
package demux4_reg_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

    typedef enum logic {
        SlotEmpty,
        SlotFull
    } slot_state_e;

    // Saturating increment; holds at CNT_MAX instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single demux output channel.
module demux_slot
    import demux4_reg_pkg::*;
#(
    parameter int unsigned bitwidth = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic                drain_i,
    input  logic [bitwidth-1:0] data_i,
    output logic                valid_o,
    output logic [bitwidth-1:0] data_o
);

    slot_state_e         state_q, state_d;
    logic [bitwidth-1:0] data_q, data_d;

    // Load has priority over drain so a same-cycle drain+load stays full.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load_i) begin
            state_d = SlotFull;
            data_d  = data_i;
        end else if (drain_i) begin
            state_d = SlotEmpty;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SlotEmpty;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = (state_q == SlotFull);
    assign data_o  = data_q;

endmodule

// File: rtl/demux4_reg.sv
// Registered 1-to-4 demultiplexer with per-channel handshake and stall counter.
module demux4_reg
    import demux4_reg_pkg::*;
#(
    parameter int unsigned bitwidth = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SEL_W-1:0]    sel,
    input  logic [bitwidth-1:0] in_data,
    output logic [NUM_CH-1:0]   out_valid,
    input  logic [NUM_CH-1:0]   out_ready,
    output logic [bitwidth-1:0] out0,
    output logic [bitwidth-1:0] out1,
    output logic [bitwidth-1:0] out2,
    output logic [bitwidth-1:0] out3,
    output logic [CNT_W-1:0]    drop_cnt
);

    logic                accept;
    logic                stall;
    logic [NUM_CH-1:0]   load;
    logic [NUM_CH-1:0]   drain;
    logic [bitwidth-1:0] slot_data [NUM_CH];
    logic [CNT_W-1:0]    drop_q, drop_d;

    always_comb begin
        in_ready = ~rst & (~out_valid[sel] | out_ready[sel]);
        accept   = in_valid & in_ready;
        stall    = in_valid & ~in_ready;
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        assign load[k]  = accept & (sel == SEL_W'(k));
        assign drain[k] = out_valid[k] & out_ready[k];

        demux_slot #(
            .bitwidth(bitwidth)
        ) u_slot (
            .clk_i  (clk),
            .rst_i  (rst),
            .load_i (load[k]),
            .drain_i(drain[k]),
            .data_i (in_data),
            .valid_o(out_valid[k]),
            .data_o (slot_data[k])
        );
    end

    always_comb begin
        drop_d = drop_q;
        if (stall) begin
            drop_d = sat_inc(drop_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign out0     = slot_data[0];
    assign out1     = slot_data[1];
    assign out2     = slot_data[2];
    assign out3     = slot_data[3];
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_demux4_reg.sv
// Directed and random stimulus for demux4_reg against a behavioural channel model.
module tb_demux4_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out0, out1, out2, out3;
    logic [7:0]  drop_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: each channel is a (full, word) pair, plus a stall count.
    bit          m_full [4];
    logic [31:0] m_word [4];
    int          m_drop;

    demux4_reg #(
        .bitwidth(32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sel      (sel),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out0     (out0),
        .out1     (out1),
        .out2     (out2),
        .out3     (out3),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready();
        if (rst) return 1'b0;
        return !m_full[sel] || out_ready[sel];
    endfunction

    function automatic logic [3:0] model_valid();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = m_full[k];
        return v;
    endfunction

    task automatic model_edge();
        bit rdy;
        rdy = model_ready();
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                m_full[k] = 0;
                m_word[k] = '0;
            end
            m_drop = 0;
        end else begin
            if (in_valid && !rdy) m_drop = (m_drop >= 255) ? 255 : m_drop + 1;
            for (int k = 0; k < 4; k++) begin
                if (in_valid && rdy && sel == k) begin
                    m_full[k] = 1;
                    m_word[k] = in_data;
                end else if (m_full[k] && out_ready[k]) begin
                    m_full[k] = 0;
                end
            end
        end
    endtask

    // One clock: check ready before the edge, advance model, check registers after.
    task automatic step(input string tag);
        #1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(model_ready()));
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(model_valid()));
        chk({tag, ".out0"}, out0, m_word[0]);
        chk({tag, ".out1"}, out1, m_word[1]);
        chk({tag, ".out2"}, out2, m_word[2]);
        chk({tag, ".out3"}, out3, m_word[3]);
        chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            m_full[k] = 0;
            m_word[k] = 32'hDEAD_BEEF;
        end
        m_drop    = 99;
        rst       = 1'b1;
        in_valid  = 1'b1;
        sel       = 2'd0;
        in_data   = 32'h1234_5678;
        out_ready = 4'b0000;
        step("reset0");
        step("reset1");

        // Reset then idle: ready for every destination.
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sel = 2'(k);
            step("idle");
            chk("idle_ready_const", 32'(in_ready), 32'd1);
        end
        chk("idle_valid_const", 32'(out_valid), 32'h0);
        chk("idle_drop_const", 32'(drop_cnt), 32'h0);

        // Routing to all four channels with no consumers.
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sel     = 2'(k);
            in_data = 32'hAAAA_0000 + 32'(k);
            step("route");
            chk("route_bit", 32'(out_valid[k]), 32'd1);
        end
        in_valid = 1'b0;
        step("route_idle");
        chk("route_valid_const", 32'(out_valid), 32'hF);
        chk("route_out0", out0, 32'hAAAA_0000);
        chk("route_out1", out1, 32'hAAAA_0001);
        chk("route_out2", out2, 32'hAAAA_0002);
        chk("route_out3", out3, 32'hAAAA_0003);

        // Backpressure on ch2 for five cycles, then release.
        in_valid = 1'b1;
        sel      = 2'd2;
        in_data  = 32'hBBBB_0002;
        for (int i = 0; i < 5; i++) step("bp_stall");
        chk("bp_drop_const", 32'(drop_cnt), 32'd5);
        chk("bp_out2_const", out2, 32'hAAAA_0002);
        out_ready = 4'b0100;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        step("bp_release");
        chk("bp_new_out2", out2, 32'hBBBB_0002);

        // Full-throughput stream to ch1.
        out_ready = 4'b1111;
        sel       = 2'd1;
        for (int i = 0; i < 16; i++) begin
            in_data = $urandom;
            step("stream");
            chk("stream_out1", out1, in_data);
        end
        in_valid = 1'b0;
        step("stream_end");

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 31) == 0);
            in_valid  = 1'($urandom);
            sel       = 2'($urandom);
            in_data   = $urandom;
            out_ready = 4'($urandom);
            step("random");
        end
        rst = 1'b0;

        // Saturation: ch0 fills and then stalls for 300 cycles.
        in_valid  = 1'b1;
        sel       = 2'd0;
        out_ready = 4'b0000;
        in_data   = 32'hCCCC_0000;
        for (int i = 0; i < 300; i++) step("sat");
        chk("sat_const", 32'(drop_cnt), 32'd255);
        for (int i = 0; i < 3; i++) step("sat_hold");
        chk("sat_hold_const", 32'(drop_cnt), 32'd255);

        // Reset mid-stream with channels 0,1,3 full.
        rst = 1'b1;
        in_valid = 1'b0;
        step("pre_rst");
        rst      = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) continue;
            sel     = 2'(k);
            in_data = 32'hDDDD_0000 + 32'(k);
            step("midrst_fill");
        end
        chk("midrst_setup", 32'(out_valid), 32'b1011);
        rst     = 1'b1;
        sel     = 2'd2;
        in_data = 32'hEEEE_0002;
        #1;
        chk("midrst_ready_const", 32'(in_ready), 32'd0);
        step("midrst");
        chk("midrst_valid_const", 32'(out_valid), 32'h0);
        chk("midrst_out2_const", out2, 32'h0);
        chk("midrst_out0_const", out0, 32'h0);
        rst      = 1'b0;
        in_valid = 1'b0;
        step("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
